hilo_sched: RTL and testbench
=============================

# hilo_sched

Issue controller for the multi-cycle HI/LO multiply/divide unit in the execute stage. It accepts HI/LO-class ALU operations from the pipeline and starts the unit. It counts the unit's fixed latency, strobes the HI/LO write at completion, and stalls any HI/LO-class request that arrives while an operation is in flight. It also aborts an in-flight operation on a pipeline flush.

## Interface
Parameters:
- `DELAY`, 2, latency of the multiply/divide unit in cycles; legal range 1..15.
- `FUNC_W`, 6, width of the Alu_Func encoding.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  execute stage presents a HI/LO-class operation.
- `req_func`  in  FUNC_W  Alu_Func code: Mul, Mulu, Div, Divu, Mthi, Mtlo, Mfhi or Mflo.
- `req_ready`  out  1  request accepted this cycle.
- `stall`  out  1  pipeline hold; equals `req_valid & ~req_ready`.
- `flush`  in  1  pipeline flush; cancels the in-flight operation.
- `unit_start`  out  1  one-cycle start pulse to the multiply/divide unit.
- `unit_func`  out  FUNC_W  registered function held for the duration of the operation.
- `unit_abort`  out  1  one-cycle pulse when a running operation is flushed.
- `hilo_we`  out  1  one-cycle write strobe: the unit result goes to HI and LO.
- `hi_we`, `lo_we`  out  1 each  Mthi / Mtlo write strobes.
- `rd_hi`  out  1  read select for Mfhi/Mflo: 1 selects HI, 0 selects LO.
- `busy`  out  1  operation in flight.

## Operation
- States: IDLE, RUN. 4-bit down-counter `cnt`.
- **IDLE, `req_valid`=1, `flush`=0:** `req_ready`=1 for every function.
  - Mul/Mulu/Div/Divu: `unit_start`=1 this cycle, `unit_func` latched, `cnt` loaded with DELAY-1, next state RUN.
  - Mthi / Mtlo: `hi_we` / `lo_we`=1 combinationally this cycle; state stays IDLE.
  - Mfhi / Mflo: `rd_hi`=1 / 0 combinationally, zero latency; state stays IDLE.
  - Any other function code: accepted as a no-op; no strobes.
- **IDLE, `flush`=1:** `req_ready`=0 and no strobes fire; state stays IDLE.
- **RUN:** `busy`=1 and `req_ready`=0, so every HI/LO-class request is stalled, including Mf*/Mt*.
  - `cnt` decrements each cycle.
  - When `cnt`==0 and `flush`=0: `hilo_we`=1 and next state IDLE.
- **RUN, `flush`=1 (any `cnt`, including the completion cycle):** flush takes priority.
  - `unit_abort`=1 and `hilo_we`=0; next state IDLE.
  - HI/LO keep their previous values.
- `rd_hi` holds its last value when no Mf* is being accepted.
- `unit_func` holds its value until the next accepted mul/div.

## Timing
- **Reset:** while `reset_n`=0, immediately drive state=IDLE, `cnt`=0, `unit_func`=0, `rd_hi`=0.
  - All strobes (`unit_start`, `unit_abort`, `hilo_we`, `hi_we`, `lo_we`) are 0 and `busy`=0; `req_ready` follows the IDLE rules.
  - Reset asserted mid-RUN abandons the operation silently: no `hilo_we`, no `unit_abort`.
- **Mul/div latency:** accept at cycle T gives `unit_start` at T, `busy` over T+1..T+DELAY, `hilo_we` at T+DELAY.
  - The next HI/LO request can be accepted at T+DELAY+1 at the earliest.
- **Back-to-back issue:** a new mul/div presented during RUN is stalled until T+DELAY+1, then starts in that cycle.
- **Mt*/Mf* in IDLE:** accepted with 0-cycle latency, one per cycle with no bubble.
- **Combinational outputs:** `req_ready`, `stall`, `unit_start`, `hi_we`, `lo_we`, `hilo_we`, `unit_abort` are combinational from state, `cnt`, `req_valid` and `flush`.
  - None depends on a unit handshake, so no combinational loop to the unit exists.

## Test plan
- **Reset:** `reset_n`=0 asynchronously mid-cycle -> all outputs 0, `busy`=0 at once. Release, then `req_valid`=1 with Mflo -> `req_ready`=1, `rd_hi`=0 in the same cycle.
- **Multu, DELAY=2:** Mulu accepted at T -> `unit_start`=1 at T, `busy`=1 at T+1 and T+2, `hilo_we`=1 only at T+2. A Mfhi presented at T+1 shows `stall`=1 at T+1 and T+2, then `req_ready`=1 with `rd_hi`=1 at T+3.
- **Mthi then Mtlo:** consecutive cycles with no mul/div running -> `hi_we`=1 at T, `lo_we`=1 at T+1, `stall`=0 throughout.
- **Flush mid-run:** Divu at T, `flush`=1 at T+1 (DELAY=2) -> `unit_abort`=1 at T+1, no `hilo_we`, `busy`=0 at T+2. Flush on the completion cycle T+2 -> `hilo_we`=0, `unit_abort`=1.
- **Flush in IDLE with `req_valid`:** Mul plus `flush`=1 -> `req_ready`=0, `unit_start`=0, state remains IDLE.
- **Back-to-back Mul, Mul:** second Mul held with `stall`=1 until T+3. It starts at T+3 and produces `hilo_we` at T+5; `unit_func` is held constant across each run.

Source files
------------

// File: rtl/hilo_sched.sv
// Issue controller for the multi-cycle HI/LO multiply/divide unit: starts the unit,
// counts its fixed latency, strobes the HI/LO write and stalls HI/LO requests meanwhile.
module hilo_sched #(
  parameter int unsigned DELAY  = 2,
  parameter int unsigned FUNC_W = 6
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic [FUNC_W-1:0] req_func,
  output logic              req_ready,
  output logic              stall,
  input  logic              flush,
  output logic              unit_start,
  output logic [FUNC_W-1:0] unit_func,
  output logic              unit_abort,
  output logic              hilo_we,
  output logic              hi_we,
  output logic              lo_we,
  output logic              rd_hi,
  output logic              busy
);

  // Alu_Func codes for the HI/LO class (MIPS SPECIAL funct field values).
  localparam logic [FUNC_W-1:0] F_MFHI = FUNC_W'(6'h10);
  localparam logic [FUNC_W-1:0] F_MTHI = FUNC_W'(6'h11);
  localparam logic [FUNC_W-1:0] F_MFLO = FUNC_W'(6'h12);
  localparam logic [FUNC_W-1:0] F_MTLO = FUNC_W'(6'h13);
  localparam logic [FUNC_W-1:0] F_MUL  = FUNC_W'(6'h18);
  localparam logic [FUNC_W-1:0] F_MULU = FUNC_W'(6'h19);
  localparam logic [FUNC_W-1:0] F_DIV  = FUNC_W'(6'h1A);
  localparam logic [FUNC_W-1:0] F_DIVU = FUNC_W'(6'h1B);

  localparam logic [3:0] CNT_LOAD = 4'(DELAY - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            r_state, w_next_state;
  logic [3:0]        r_cnt, w_next_cnt;
  logic [FUNC_W-1:0] r_unit_func;
  logic              r_rd_hi;

  logic w_take;
  logic w_is_md;
  logic w_is_mf;

  assign w_is_md = (req_func == F_MUL) || (req_func == F_MULU) ||
                   (req_func == F_DIV) || (req_func == F_DIVU);
  assign w_is_mf = (req_func == F_MFHI) || (req_func == F_MFLO);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_unit_func <= '0;
      r_rd_hi     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_take && w_is_md) r_unit_func <= req_func;
      if (w_take && w_is_mf) r_rd_hi     <= (req_func == F_MFHI);
    end
  end

  // NOTE: every always_comb target gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_take && w_is_md) begin
          w_next_state = RUN;
          w_next_cnt   = CNT_LOAD;
        end
      end
      RUN: begin
        if (flush || (r_cnt == 4'd0)) begin
          w_next_state = IDLE;
          w_next_cnt   = 4'd0;
        end else begin
          w_next_cnt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_cnt   = 4'd0;
      end
    endcase
  end

  // Strobes are additionally gated by reset_n so nothing fires while reset is held.
  always_comb begin
    req_ready  = (r_state == IDLE) && req_valid && !flush;
    w_take     = req_ready && reset_n;
    stall      = req_valid && !req_ready;
    busy       = (r_state == RUN);
    unit_start = w_take && w_is_md;
    hi_we      = w_take && (req_func == F_MTHI);
    lo_we      = w_take && (req_func == F_MTLO);
    hilo_we    = (r_state == RUN) && (r_cnt == 4'd0) && !flush;
    unit_abort = (r_state == RUN) && flush;
    rd_hi      = (w_take && w_is_mf) ? (req_func == F_MFHI) : r_rd_hi;
    unit_func  = r_unit_func;
  end

endmodule

// File: tb/tb_hilo_sched.sv
// Directed self-checking bench for hilo_sched (DELAY=2): reset, mul/div timing,
// Mt*/Mf* zero-latency issue, flush in RUN and IDLE, back-to-back stalls.
module tb_hilo_sched;

  localparam int FUNC_W = 6;
  localparam logic [5:0] MFHI = 6'h10, MTHI = 6'h11, MFLO = 6'h12, MTLO = 6'h13;
  localparam logic [5:0] MUL  = 6'h18, MULU = 6'h19, DIV  = 6'h1A, DIVU = 6'h1B;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              req_valid;
  logic [FUNC_W-1:0] req_func;
  logic              req_ready, stall, flush, unit_start, unit_abort;
  logic [FUNC_W-1:0] unit_func;
  logic              hilo_we, hi_we, lo_we, rd_hi, busy;

  int n_total = 0;
  int n_pass  = 0;

  hilo_sched #(.DELAY(2), .FUNC_W(FUNC_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_func(req_func), .req_ready(req_ready),
    .stall(stall), .flush(flush), .unit_start(unit_start), .unit_func(unit_func),
    .unit_abort(unit_abort), .hilo_we(hilo_we), .hi_we(hi_we), .lo_we(lo_we),
    .rd_hi(rd_hi), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic drive(input logic v, input logic [5:0] f, input logic fl);
    req_valid = v;
    req_func  = f;
    flush     = fl;
  endtask

  // Sample mid-cycle, then advance to just after the next rising edge.
  task automatic sample();
    @(negedge clock);
  endtask

  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 6'h00, 1'b0);
    #3;
    check("rst_busy", busy, 0);
    check("rst_strobes", {unit_start, unit_abort, hilo_we, hi_we, lo_we}, 0);
    check("rst_rd_hi", rd_hi, 0);
    check("rst_unit_func", unit_func, 0);
    check("rst_stall", stall, 0);
    @(negedge clock);
    reset_n = 1'b1;
    adv();

    // Mflo right after reset release
    drive(1'b1, MFLO, 1'b0); sample();
    check("mflo_ready", req_ready, 1);
    check("mflo_rd_hi", rd_hi, 0);
    adv();

    // Mulu at T, Mfhi presented from T+1
    drive(1'b1, MULU, 1'b0); sample();
    check("mulu_T_start", unit_start, 1);
    check("mulu_T_busy", busy, 0);
    adv();
    drive(1'b1, MFHI, 1'b0); sample();
    check("mulu_T1_busy", busy, 1);
    check("mulu_T1_stall", stall, 1);
    check("mulu_T1_hilo_we", hilo_we, 0);
    check("mulu_T1_func", unit_func, MULU);
    adv(); sample();
    check("mulu_T2_busy", busy, 1);
    check("mulu_T2_stall", stall, 1);
    check("mulu_T2_hilo_we", hilo_we, 1);
    check("mulu_T2_start", unit_start, 0);
    adv(); sample();
    check("mfhi_T3_ready", req_ready, 1);
    check("mfhi_T3_rd_hi", rd_hi, 1);
    check("mfhi_T3_busy", busy, 0);
    check("mfhi_T3_hilo_we", hilo_we, 0);
    adv();
    drive(1'b0, 6'h00, 1'b0); sample();
    check("rd_hi_hold", rd_hi, 1);
    adv();

    // Mthi then Mtlo back to back
    drive(1'b1, MTHI, 1'b0); sample();
    check("mthi_we", {hi_we, lo_we, stall}, 3'b100);
    adv();
    drive(1'b1, MTLO, 1'b0); sample();
    check("mtlo_we", {hi_we, lo_we, stall}, 3'b010);
    adv();

    // Divu flushed at T+1
    drive(1'b1, DIVU, 1'b0); sample();
    check("divu_start", unit_start, 1);
    adv();
    drive(1'b0, 6'h00, 1'b1); sample();
    check("flush_T1_abort", unit_abort, 1);
    check("flush_T1_hilo_we", hilo_we, 0);
    adv();
    drive(1'b0, 6'h00, 1'b0); sample();
    check("flush_T2_busy", busy, 0);
    check("flush_T2_strobes", {hilo_we, unit_abort}, 0);
    adv();

    // Div flushed on its completion cycle
    drive(1'b1, DIV, 1'b0); sample();
    check("div_start", unit_start, 1);
    adv();
    drive(1'b0, 6'h00, 1'b0); sample();
    check("div_T1", {busy, unit_abort}, 2'b10);
    adv();
    drive(1'b0, 6'h00, 1'b1); sample();
    check("flush_done_hilo_we", hilo_we, 0);
    check("flush_done_abort", unit_abort, 1);
    adv();
    drive(1'b0, 6'h00, 1'b0); sample();
    check("flush_done_busy", busy, 0);
    adv();

    // Flush in IDLE with a Mul presented
    drive(1'b1, MUL, 1'b1); sample();
    check("idle_flush_ready", req_ready, 0);
    check("idle_flush_start", unit_start, 0);
    check("idle_flush_stall", stall, 1);
    adv();
    drive(1'b0, 6'h00, 1'b0); sample();
    check("idle_flush_busy", busy, 0);
    check("idle_flush_func_held", unit_func, DIV);
    adv();

    // Back-to-back Mul, Mul
    drive(1'b1, MUL, 1'b0); sample();
    check("b2b_T_start", unit_start, 1);
    adv(); sample();
    check("b2b_T1", {stall, unit_start, hilo_we}, 3'b100);
    check("b2b_T1_func", unit_func, MUL);
    adv(); sample();
    check("b2b_T2", {stall, unit_start, hilo_we}, 3'b101);
    adv(); sample();
    check("b2b_T3", {stall, unit_start, req_ready, hilo_we}, 4'b0110);
    adv();
    drive(1'b1, MTHI, 1'b0); sample();
    check("b2b_T4", {busy, hilo_we, hi_we, stall}, 4'b1001);
    check("b2b_T4_func", unit_func, MUL);
    adv();
    drive(1'b0, 6'h00, 1'b0); sample();
    check("b2b_T5_hilo_we", hilo_we, 1);
    adv(); sample();
    check("b2b_T6_busy", busy, 0);
    adv();

    // Unknown function code is an accepted no-op
    drive(1'b1, 6'h20, 1'b0); sample();
    check("nop_ready", req_ready, 1);
    check("nop_strobes", {unit_start, hi_we, lo_we, hilo_we, unit_abort}, 0);
    adv(); sample();
    check("nop_busy", busy, 0);
    adv();

    // Asynchronous reset mid-run
    drive(1'b1, MULU, 1'b0); sample();
    check("arst_start", unit_start, 1);
    adv();
    drive(1'b0, 6'h00, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_strobes", {hilo_we, unit_abort, unit_start}, 0);
    check("arst_func", unit_func, 0);
    @(negedge clock);
    reset_n = 1'b1;
    adv(); sample();
    check("arst_after", {busy, hilo_we, unit_abort}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
